// File: rtl/xbar_out_fifo.sv
// ----------------------------------------------------------------------------
// xbar_out_fifo
//
// Per-output-port request FIFO that sits on one output of the n-to-4 request
// crossbar. It holds the arbitrated request stream for the downstream cache
// bank pipeline. Bank backpressure therefore never reaches crossbar
// arbitration combinationally: in_rdy depends only on registered occupancy.
//
// Parameters
//   PLD_WIDTH  payload width in bits (must match the crossbar)
//   DEPTH      number of entries, power of two, >= 2
//   AFULL_TH   occupancy at or above which almost_full asserts (1..DEPTH)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (priority over flush)
//   flush        synchronous clear of all entries (pipeline kill)
//   in_vld       crossbar output valid
//   in_pld       crossbar output payload
//   in_rdy       FIFO can accept; drives the crossbar out_rdy for this port
//   out_vld      head entry valid toward the bank
//   out_pld      head entry payload
//   out_rdy      bank accepts the head entry
//   count        current occupancy
//   almost_full  count >= AFULL_TH
// ----------------------------------------------------------------------------
module xbar_out_fifo #(
    parameter int PLD_WIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_vld,
    input  logic [PLD_WIDTH-1:0]         in_pld,
    output logic                         in_rdy,
    output logic                         out_vld,
    output logic [PLD_WIDTH-1:0]         out_pld,
    input  logic                         out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    logic [PLD_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake flags come from registered occupancy only, so there is no
    // combinational path from out_rdy to in_rdy and no fall-through on full.
    assign in_rdy      = (count_q != FULL_CNT);
    assign out_vld     = (count_q != '0);
    assign out_pld     = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_CNT);

    assign push = in_vld  && in_rdy;
    assign pop  = out_vld && out_rdy;

    // Next-state logic. DEPTH is a power of two, so the pointers wrap
    // naturally from DEPTH-1 back to 0.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a variable unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Control state. rst and flush both clear; any push or pop presented in
    // the clearing cycle is discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage.
    // NOTE: the memory has no reset; entries are only ever read while the
    // occupancy says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem_q[wr_ptr_q] <= in_pld;
        end
    end

endmodule

// File: tb/tb_xbar_out_fifo.sv
// ----------------------------------------------------------------------------
// tb_xbar_out_fifo
//
// Scoreboard bench for xbar_out_fifo. The driver issues stimulus one cycle at
// a time; whenever it predicts an accepted push it queues the payload as an
// expected response, and a flush or reset empties the queue. The monitor runs
// on the falling edge, compares the DUT against the queue (occupancy, flags,
// head payload) and pops the queue on every predicted handshake.
// ----------------------------------------------------------------------------
module tb_xbar_out_fifo;

    localparam int PLD_WIDTH = 32;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = DEPTH - 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 in_vld;
    logic [PLD_WIDTH-1:0] in_pld;
    logic                 in_rdy;
    logic                 out_vld;
    logic [PLD_WIDTH-1:0] out_pld;
    logic                 out_rdy;
    logic [CNT_W-1:0]     count;
    logic                 almost_full;

    xbar_out_fifo #(
        .PLD_WIDTH (PLD_WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_vld      (in_vld),
        .in_pld      (in_pld),
        .in_rdy      (in_rdy),
        .out_vld     (out_vld),
        .out_pld     (out_pld),
        .out_rdy     (out_rdy),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;

    // Reference model: the ordered list of entries the FIFO should hold.
    logic [PLD_WIDTH-1:0] exp_q [$];

    bit                   mon_en     = 1'b0;
    bit                   pend_clear = 1'b1;
    bit                   pend_push  = 1'b0;
    logic [PLD_WIDTH-1:0] pend_pld   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. The effect of the previous cycle's inputs is
    // applied to the model at the edge, then new inputs are driven.
    task automatic step(input logic v, input logic [31:0] p, input logic ordy,
                        input logic fl, input logic rs);
        @(posedge clk);
        if (pend_clear) begin
            exp_q.delete();
        end else if (pend_push) begin
            exp_q.push_back(pend_pld);
        end
        #1;
        in_vld  = v;
        in_pld  = p;
        out_rdy = ordy;
        flush   = fl;
        rst     = rs;
        pend_clear = fl || rs;
        pend_push  = !pend_clear && v && (exp_q.size() != DEPTH);
        pend_pld   = p;
        if (pend_push) n_pushed++;
    endtask

    // Monitor: compare against the model in mid-cycle, then retire the head
    // if the bank takes it this cycle.
    int es;
    always @(negedge clk) begin
        if (mon_en) begin
            es = exp_q.size();
            check("count",       32'(count),       32'(es));
            check("in_rdy",      32'(in_rdy),      32'(es != DEPTH));
            check("out_vld",     32'(out_vld),     32'(es != 0));
            check("almost_full", 32'(almost_full), 32'(es >= AFULL_TH));
            if (es != 0) begin
                check("out_pld", out_pld, exp_q[0]);
                if (out_rdy && !rst && !flush) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_pld  = '0;
        out_rdy = 1'b0;

        // Reset: state is checked by the monitor from the first reset edge.
        step(0, 0, 0, 0, 1);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 0);

        // Single push: visible one cycle later, gone the cycle after.
        step(1, 32'hA5A5_0001, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("single_vld", 32'(out_vld), 32'd1);
        check("single_pld", out_pld, 32'hA5A5_0001);
        step(0, 0, 1, 0, 0);
        check("single_cnt", 32'(count), 32'd0);

        // Fill and block.
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0);
        check("full_rdy", 32'(in_rdy), 32'd0);
        check("full_cnt", 32'(count), 32'd4);
        check("full_af",  32'(almost_full), 32'd1);
        step(1, 5, 1, 0, 0);
        check("full_rdy_pop", 32'(in_rdy), 32'd0);
        step(1, 5, 0, 0, 0);
        check("after_pop_rdy", 32'(in_rdy), 32'd1);
        check("after_pop_cnt", 32'(count), 32'd3);
        step(0, 0, 1, 0, 0);
        check("refill_cnt", 32'(count), 32'd4);
        repeat (6) step(0, 0, 1, 0, 0);
        check("drain_cnt", 32'(count), 32'd0);

        // Simultaneous push and pop at count 2, across pointer wrap.
        step(1, 100, 0, 0, 0);
        step(1, 101, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 200 + i, 1, 0, 0);
            check("pushpop_cnt", 32'(count), 32'd2);
        end
        repeat (4) step(0, 0, 1, 0, 0);

        // Random traffic against 30% bank acceptance.
        n_pushed = 0;
        for (int c = 0; c < 20000 && n_pushed < 1000; c++) begin
            step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 9) < 3, 0, 0);
        end
        check("bp_budget", 32'(n_pushed >= 1000), 32'd1);
        repeat (8) step(0, 0, 1, 0, 0);

        // Flush at count 3 with push and pop in the same cycle.
        step(1, 301, 0, 0, 0);
        step(1, 302, 0, 0, 0);
        step(1, 303, 0, 0, 0);
        check("pre_flush_cnt", 32'(count), 32'd2);
        step(1, 32'hDEAD_BEEF, 1, 1, 0);
        check("flush_cyc_rdy", 32'(in_rdy), 32'd1);
        step(0, 0, 1, 0, 0);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_vld", 32'(out_vld), 32'd0);
        check("flush_rdy", 32'(in_rdy), 32'd1);
        repeat (2) step(0, 0, 1, 0, 0);

        // Reset mid-stream at count 4, then reset together with flush.
        for (int i = 0; i < 4; i++) step(1, 400 + i, 0, 0, 0);
        step(1, 32'hBAD0_0001, 1, 0, 1);
        check("rst_pre_cnt", 32'(count), 32'd4);
        step(0, 0, 0, 0, 0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 500 + i, 0, 0, 0);
        step(1, 32'hBAD0_0002, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        check("rstfl_cnt", 32'(count), 32'd0);
        check("rstfl_vld", 32'(out_vld), 32'd0);
        check("rstfl_rdy", 32'(in_rdy), 32'd1);
        step(1, 32'h0000_0777, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("post_rst_vld", 32'(out_vld), 32'd1);
        check("post_rst_pld", out_pld, 32'h0000_0777);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);
        end
        repeat (8) step(0, 0, 1, 0, 0);
        check("final_cnt", 32'(count), 32'd0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
